uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UartTx transmitter between NrOfRequesters byte sources on the clock board, such as the time-display sender and the debug/status reporter. It arbitrates round-robin and latches the winning byte. It drives UartTx startTransmission/dataBits and tracks UartTx ready through the whole frame, so only one frame is in flight and dataBits stays stable while UartTx samples it bit by bit.

Parameters:
NrOfRequesters, 4, number of requesters (>=2)
NrOfDataBits, 8, byte width; equals UartTx NrOfDataBits

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NrOfRequesters  per-requester request; held high while reqData valid
reqData  input  NrOfRequesters*NrOfDataBits  flat data; requester i occupies bits [i*NrOfDataBits +: NrOfDataBits]
grant  output  NrOfRequesters  one-hot, one-cycle pulse: requester's byte captured
grantIndex  output  clog2(NrOfRequesters)  index of last granted requester
txStart  output  1  to UartTx startTransmission; one-cycle pulse
txData  output  NrOfDataBits  to UartTx dataBits; registered, stable for the whole frame
txReady  input  1  from UartTx ready
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: single clock "clock"; "reset" is synchronous and active-high. All outputs are registered.
- Reset values:
  - grant=0, txStart=0, txData=0, busy=0, state=IDLE.
  - grantIndex=NrOfRequesters-1, so requester 0 has top priority after reset.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE, when txReady=1 and any req bit is high:
  - Select the first set req, scanning from grantIndex+1 upward with wrap-around modulo NrOfRequesters.
  - Next cycle: txData<=that requester's byte, grant[i]=1 for exactly one cycle, grantIndex<=i, state<=START.
  - If txReady=0 in IDLE, wait; no grant.
- START: txStart=1 for exactly this one cycle; next state WAIT_BUSY.
- WAIT_BUSY:
  - UartTx raises its start bit only at its next baud tick, so txReady may stay high up to ClockFrequency/BaudRate cycles.
  - Stay here until txReady=0, then go to WAIT_DONE.
  - txStart is not re-issued.
- WAIT_DONE: stay until txReady=1, then go to IDLE. The next arbitration happens no earlier than the cycle after txReady rises.
- Latency:
  - req sampled high at edge k (IDLE, txReady=1) gives grant in cycle k+1 and txStart in cycle k+2.
  - Back-to-back frames: the next grant is one cycle after txReady returns high.
- Requester handshake:
  - A requester may change reqData or drop req from the cycle after its grant pulse.
  - req dropped before grant means not served and not latched; no request memory exists.
  - Changing reqData of a non-granted requester never affects txData.
- Simultaneous requests: exactly one grant per frame, round-robin order. A continuously requesting source waits at most NrOfRequesters-1 frames.
- txData holds its value from grant until the next grant. It never changes in START, WAIT_BUSY or WAIT_DONE.
- grant and txStart are never high in the same cycle.
- Reset in any state:
  - The next cycle shows reset values and the frame is abandoned.
  - If UartTx is not reset together, the arbiter waits in IDLE for txReady=1 before granting.

Test Plan:
(Bench: UartTx instance with ClockFrequency=24_000_000 and BaudRate=2_400_000, i.e. 10 clocks/bit; 4 requesters.)
1. req[0]=1 with byte 0xA5, others idle -> grant=0001 for one cycle; txStart one pulse the next cycle. tx shows start 0, bits 1,0,1,0,0,1,0,1 (LSB first), stop 1. busy falls the cycle after ready rises.
2. req=1111 held, bytes 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3. Frames carry 0x11,0x22,0x33,0x44 with no overlap. txStart count = 4.
3. req[0] and req[2] held continuously for 6 frames -> grant sequence 0,2,0,2,0,2. grantIndex tracks each grant.
4. req[3] pulsed for one cycle while busy -> never granted; grant[3] stays 0 through 3 frames.
5. reqData[0] changed to 0xFF mid-frame after grant of 0x3C -> tx bits still show 0x3C; txData=0x3C until the next grant.
6. reset asserted during WAIT_DONE -> next cycle busy=0, txStart=0, grant=0, grantIndex=3. After reset, with req=1111, the first grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte sources share one UartTx.
// It latches the winning byte and holds it stable until UartTx reports the whole frame done.
module uart_tx_arbiter #(
    parameter int NrOfRequesters = 4,
    parameter int NrOfDataBits   = 8
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [NrOfRequesters-1:0]                req,
    input  logic [NrOfRequesters*NrOfDataBits-1:0]   reqData,
    output logic [NrOfRequesters-1:0]                grant,
    output logic [$clog2(NrOfRequesters)-1:0]        grantIndex,
    output logic                                     txStart,
    output logic [NrOfDataBits-1:0]                  txData,
    input  logic                                     txReady,
    output logic                                     busy
);

    localparam int IdxW = $clog2(NrOfRequesters);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [NrOfRequesters-1:0] grant_q, grant_d;
    logic [IdxW-1:0]           grant_index_q, grant_index_d;
    logic                      tx_start_q, tx_start_d;
    logic [NrOfDataBits-1:0]   tx_data_q, tx_data_d;
    logic                      busy_q, busy_d;

    logic                      sel_valid_s;
    logic [IdxW-1:0]           sel_idx_s;

    // Round-robin pick: scan downward so the smallest offset past grantIndex wins.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = {IdxW{1'b0}};
        for (int off = NrOfRequesters; off >= 1; off--) begin
            int idx;
            idx = (int'(grant_index_q) + off) % NrOfRequesters;
            if (req[IdxW'(idx)]) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = IdxW'(idx);
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Frame-level FSM; txReady is tracked both falling and rising so only one frame is ever in flight.
    always_comb begin
        state_d       = state_q;
        grant_d       = {NrOfRequesters{1'b0}};
        grant_index_d = grant_index_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        case (state_q)
            IDLE: begin
                if (txReady && sel_valid_s) begin
                    state_d            = START;
                    grant_d[sel_idx_s] = 1'b1;
                    grant_index_d      = sel_idx_s;
                    tx_data_d          = reqData[int'(sel_idx_s)*NrOfDataBits +: NrOfDataBits];
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d    = WAIT_BUSY;
                tx_start_d = 1'b1;
            end
            WAIT_BUSY: begin
                // UartTx only drops ready at its next baud tick, which may be many cycles away.
                if (!txReady) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (txReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= {NrOfRequesters{1'b0}};
            grant_index_q <= IdxW'(NrOfRequesters - 1);
            tx_start_q    <= 1'b0;
            tx_data_q     <= {NrOfDataBits{1'b0}};
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_index_q <= grant_index_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
        end
    end

    assign grant      = grant_q;
    assign grantIndex = grant_index_q;
    assign txStart    = tx_start_q;
    assign txData     = tx_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of round-robin frames plus hand-written
// sequences for mid-frame pulses, data changes and reset during a frame. txReady is driven by the bench.
module tb_uart_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  grant;
    logic [1:0]  grantIndex;
    logic        txStart;
    logic [7:0]  txData;
    logic        txReady;
    logic        busy;

    int checks = 0;
    int passed = 0;

    uart_tx_arbiter #(.NrOfRequesters(4), .NrOfDataBits(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .reqData    (reqData),
        .grant      (grant),
        .grantIndex (grantIndex),
        .txStart    (txStart),
        .txData     (txData),
        .txReady    (txReady),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] dat;
        int          idx;
        logic [7:0]  byt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end else begin
            passed++;
        end
    endtask

    // One complete frame: wait for grant, check txStart pulse, emulate UartTx ready low/high.
    task automatic serve(input string nm, input logic [3:0] rq, input logic [31:0] dat,
                         input int exp_idx, input logic [7:0] exp_byte,
                         input logic [3:0] pulse, input logic chg, input logic [31:0] chg_data);
        int   n;
        logic ok;
        logic [3:0] exp_grant;
        exp_grant = 4'b0001 << exp_idx;
        req     = rq;
        reqData = dat;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (grant === 4'b0000 && n < 30);
        if (grant === 4'b0000) begin
            chk({nm, "_grant_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({nm, "_grant"}, grant, exp_grant);
        chk({nm, "_grantIndex"}, grantIndex, exp_idx);
        chk({nm, "_txData"}, txData, exp_byte);
        chk({nm, "_noStartWithGrant"}, txStart, 1'b0);
        if (chg) reqData = chg_data;
        @(negedge clock);
        chk({nm, "_txStart"}, txStart, 1'b1);
        chk({nm, "_grantPulse"}, grant, 4'b0000);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (txStart !== 1'b0 || busy !== 1'b1 || grant !== 4'b0000) ok = 1'b0;
        end
        chk({nm, "_waitBusy"}, ok, 1'b1);
        txReady = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) req = rq | pulse;
            if (i == 6) req = rq;
            @(negedge clock);
            if (txData !== exp_byte || grant !== 4'b0000 || busy !== 1'b1 || txStart !== 1'b0) ok = 1'b0;
        end
        chk({nm, "_frameStable"}, ok, 1'b1);
        txReady = 1'b1;
        @(negedge clock);
        chk({nm, "_busyFall"}, busy, 1'b0);
    endtask

    initial begin
        logic ok;
        int   n;

        vecs[0]  = '{4'b0001, 32'h000000A5, 0, 8'hA5};
        vecs[1]  = '{4'b1111, 32'h44332211, 1, 8'h22};
        vecs[2]  = '{4'b1111, 32'h44332211, 2, 8'h33};
        vecs[3]  = '{4'b1111, 32'h44332211, 3, 8'h44};
        vecs[4]  = '{4'b1111, 32'h44332211, 0, 8'h11};
        vecs[5]  = '{4'b0101, 32'h44332211, 2, 8'h33};
        vecs[6]  = '{4'b0101, 32'h44332211, 0, 8'h11};
        vecs[7]  = '{4'b0101, 32'h44332211, 2, 8'h33};
        vecs[8]  = '{4'b0101, 32'h44332211, 0, 8'h11};
        vecs[9]  = '{4'b0101, 32'h44332211, 2, 8'h33};
        vecs[10] = '{4'b0101, 32'h44332211, 0, 8'h11};
        vecs[11] = '{4'b1000, 32'h44332211, 3, 8'h44};
        vecs[12] = '{4'b0110, 32'h44332211, 1, 8'h22};
        vecs[13] = '{4'b1001, 32'h44332211, 3, 8'h44};
        vecs[14] = '{4'b0010, 32'h44332211, 1, 8'h22};

        reset   = 1'b1;
        req     = 4'b0000;
        reqData = 32'h0;
        txReady = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_txStart", txStart, 1'b0);
        chk("rst_txData", txData, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grantIndex", grantIndex, 2'd3);
        reset = 1'b0;

        for (int v = 0; v < 15; v++) begin
            serve($sformatf("vec%0d", v), vecs[v].rq, vecs[v].dat, vecs[v].idx, vecs[v].byt,
                  4'b0000, 1'b0, 32'h0);
        end

        // req[3] pulsed mid-frame must never be served
        serve("pulse_a", 4'b0001, 32'h44332211, 0, 8'h11, 4'b1000, 1'b0, 32'h0);
        serve("pulse_b", 4'b0001, 32'h44332211, 0, 8'h11, 4'b1000, 1'b0, 32'h0);
        serve("pulse_c", 4'b0001, 32'h44332211, 0, 8'h11, 4'b0000, 1'b0, 32'h0);

        // data change after grant does not disturb the frame in flight
        serve("chg_a", 4'b0001, 32'h0000003C, 0, 8'h3C, 4'b0000, 1'b1, 32'h000000FF);
        serve("chg_b", 4'b0001, 32'h000000FF, 0, 8'hFF, 4'b0000, 1'b0, 32'h0);

        // reset while waiting for the frame to finish
        req     = 4'b0001;
        reqData = 32'h44332211;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (grant === 4'b0000 && n < 30);
        chk("rst6_grant", grant, 4'b0001);
        @(negedge clock);
        @(negedge clock);
        txReady = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst6_busyBefore", busy, 1'b1);
        reset = 1'b1;
        req   = 4'b1111;
        @(negedge clock);
        chk("rst6_busy", busy, 1'b0);
        chk("rst6_txStart", txStart, 1'b0);
        chk("rst6_grant0", grant, 4'b0000);
        chk("rst6_grantIndex", grantIndex, 2'd3);
        chk("rst6_txData", txData, 8'h00);
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (grant !== 4'b0000 || busy !== 1'b0) ok = 1'b0;
        end
        chk("rst6_waitReady", ok, 1'b1);
        txReady = 1'b1;
        serve("rst6_after", 4'b1111, 32'h44332211, 0, 8'h11, 4'b0000, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
